// File: rtl/inv_sqrt_pipe.sv
`default_nettype none
// ============================================================================
// Module      : inv_sqrt_pipe
// Description : Streaming reciprocal square root, result = 2^15/sqrt(d),
//               unsigned Q1.15. Normalise -> LUT lookup -> shift, with
//               ready/valid backpressure and a pass-through tag.
//               The LUT is built at elaboration from its defining formula
//               floor(2^15/sqrt((1 + j/2^(LUT_AW-1)) * 2^p)), so no memory
//               image has to be loaded.
//               Optional build macro INV_SQRT_INTERP_EN adds a lookup stage
//               and linear interpolation between adjacent LUT entries
//               (latency 3 instead of 2).
// Revision    : 1.0  initial release
// ============================================================================
module inv_sqrt_pipe #(
    parameter int D_W      = 14,
    parameter int OUT_W    = 16,
    parameter int LUT_AW   = 8,
    parameter int TAG_W    = 4,
    parameter int INTERP_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [D_W-1:0]   d_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OUT_W-1:0] result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             zero_o
);

    // Mantissa bits addressing one parity half of the LUT.
    localparam int c_man_w = LUT_AW - 1;
    // Width of the leading-one index k (and of the derived shift).
    localparam int c_k_w   = $clog2(D_W);
    // Normalisation vector: operand followed by mantissa and fraction slots.
    localparam int c_ext_w = D_W + c_man_w + INTERP_W;
    localparam int c_lut_n = 1 << LUT_AW;

    // ------------------------------------------------------------------------
    // LUT entry: floor(sqrt(2^(30+M-p) / (2^M + j))) equals
    // floor(2^15 / sqrt((1 + j/2^M) * 2^p)); the integer square root of the
    // floored quotient gives the same floor as the exact real value.
    // ------------------------------------------------------------------------
    function automatic logic [OUT_W-1:0] lut_entry(input int idx);
        logic [63:0] num;
        logic [63:0] den;
        logic [63:0] x;
        logic [63:0] r;
        logic [63:0] t;
        int          p;
        int          j;
        p   = idx >> c_man_w;
        j   = idx & ((1 << c_man_w) - 1);
        num = 64'd1 << (30 + c_man_w - p);
        den = 64'((1 << c_man_w) + j);
        x   = num / den;
        r   = '0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= x) begin
                r = t;
            end
        end
        return OUT_W'(r);
    endfunction

    logic [OUT_W-1:0] w_lut [c_lut_n];

    generate
        for (genvar gi = 0; gi < c_lut_n; gi++) begin : g_lut
            assign w_lut[gi] = lut_entry(gi);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Pipeline advance: every stage moves together, so bubbles are kept.
    // ------------------------------------------------------------------------
    logic w_en;
    assign w_en    = !valid_o || ready_i;
    assign ready_o = w_en;

    // ------------------------------------------------------------------------
    // Stage 1 combinational: leading-one detect and left alignment
    // ------------------------------------------------------------------------
    logic [c_k_w-1:0]   w_k;
    logic [c_k_w-1:0]   w_lsh;
    logic [c_ext_w-1:0] w_ext;
    logic [c_man_w-1:0] w_man;
    logic [INTERP_W-1:0] w_frac;
    logic [LUT_AW-1:0]  w_addr;
    logic [c_k_w-1:0]   w_shift;

    // Leading-one index; the highest set bit overrides lower ones.
    always_comb begin
        w_k = '0;
        for (int i = 0; i < D_W; i++) begin
            if (d_i[i]) begin
                w_k = c_k_w'(i);
            end
        end
    end

    // Shift the leading one to the MSB; the bits right of it are the mantissa
    // followed by the interpolation fraction, zero-filled from the right.
    assign w_lsh   = c_k_w'(D_W - 1) - w_k;
    assign w_ext   = {d_i, {(c_man_w + INTERP_W){1'b0}}} << w_lsh;
    assign w_man   = w_ext[c_ext_w-2 -: c_man_w];
    assign w_frac  = w_ext[c_ext_w-2-c_man_w -: INTERP_W];
    assign w_addr  = {w_k[0], w_man};
    assign w_shift = w_k >> 1;

    // ------------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------------
    logic                r_s1_valid;
    logic [LUT_AW-1:0]   r_s1_addr;
    logic [c_k_w-1:0]    r_s1_shift;
    logic                r_s1_zero;
    logic [TAG_W-1:0]    r_s1_tag;

    // Capture the normalised operand whenever the pipeline advances.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_shift <= '0;
            r_s1_zero  <= 1'b0;
            r_s1_tag   <= '0;
        end else if (w_en) begin
            r_s1_valid <= valid_i;
            r_s1_addr  <= w_addr;
            r_s1_shift <= w_shift;
            r_s1_zero  <= (d_i == '0);
            r_s1_tag   <= tag_i;
        end
    end

    // Values presented to the output register by the last compute stage.
    logic             w_fin_valid;
    logic [OUT_W-1:0] w_fin_y;
    logic [TAG_W-1:0] w_fin_tag;
    logic             w_fin_zero;

    // The leading one itself and the operand tail below the fraction slots
    // carry no information after alignment.
    logic w_unused_bits;

`ifdef INV_SQRT_INTERP_EN
    // ------------------------------------------------------------------------
    // Interpolating build: fraction register, extra lookup stage, blend
    // ------------------------------------------------------------------------
    logic [INTERP_W-1:0] r_s1_frac;

    // Fraction travels alongside the stage-1 fields.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_frac <= '0;
        end else if (w_en) begin
            r_s1_frac <= w_frac;
        end
    end

    logic             w_last;
    logic [OUT_W-1:0] w_y0;
    logic [OUT_W-1:0] w_y1;

    // Neighbour entry; the last entry of each parity half has no neighbour
    // in the same half, so it interpolates against itself.
    assign w_last = &r_s1_addr[c_man_w-1:0];
    assign w_y0   = w_lut[r_s1_addr];
    assign w_y1   = w_last ? w_y0 : w_lut[r_s1_addr + LUT_AW'(1)];

    logic                r_s2_valid;
    logic [OUT_W-1:0]    r_s2_y0;
    logic [OUT_W-1:0]    r_s2_y1;
    logic [INTERP_W-1:0] r_s2_frac;
    logic [c_k_w-1:0]    r_s2_shift;
    logic                r_s2_zero;
    logic [TAG_W-1:0]    r_s2_tag;

    // Lookup stage register: both LUT neighbours plus the sideband.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s2_valid <= 1'b0;
            r_s2_y0    <= '0;
            r_s2_y1    <= '0;
            r_s2_frac  <= '0;
            r_s2_shift <= '0;
            r_s2_zero  <= 1'b0;
            r_s2_tag   <= '0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_y0    <= w_y0;
            r_s2_y1    <= w_y1;
            r_s2_frac  <= r_s1_frac;
            r_s2_shift <= r_s1_shift;
            r_s2_zero  <= r_s1_zero;
            r_s2_tag   <= r_s1_tag;
        end
    end

    // The LUT is monotonically decreasing inside a half, so y0 >= y1 and the
    // correction never exceeds the difference.
    logic [OUT_W-1:0]          w_diff;
    logic [OUT_W+INTERP_W-1:0] w_prod;
    logic [OUT_W-1:0]          w_corr;
    logic [OUT_W-1:0]          w_interp;

    assign w_diff   = r_s2_y0 - r_s2_y1;
    assign w_prod   = (OUT_W+INTERP_W)'(w_diff) * (OUT_W+INTERP_W)'(r_s2_frac);
    assign w_corr   = OUT_W'(w_prod >> INTERP_W);
    assign w_interp = r_s2_y0 - w_corr;

    assign w_fin_valid = r_s2_valid;
    assign w_fin_y     = r_s2_zero ? {OUT_W{1'b1}} : (w_interp >> r_s2_shift);
    assign w_fin_tag   = r_s2_tag;
    assign w_fin_zero  = r_s2_zero;

    assign w_unused_bits = ^{w_ext[c_ext_w-1], w_ext[D_W-2:0]};
`else
    // ------------------------------------------------------------------------
    // Plain build: lookup and shift feed the output register directly
    // ------------------------------------------------------------------------
    assign w_fin_valid = r_s1_valid;
    assign w_fin_y     = r_s1_zero ? {OUT_W{1'b1}} : (w_lut[r_s1_addr] >> r_s1_shift);
    assign w_fin_tag   = r_s1_tag;
    assign w_fin_zero  = r_s1_zero;

    assign w_unused_bits = ^{w_ext[c_ext_w-1], w_frac, w_ext[D_W-2:0]};
`endif

    // ------------------------------------------------------------------------
    // Output register; holds while downstream stalls.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o  <= 1'b0;
            result_o <= '0;
            tag_o    <= '0;
            zero_o   <= 1'b0;
        end else if (w_en) begin
            valid_o  <= w_fin_valid;
            result_o <= w_fin_y;
            tag_o    <= w_fin_tag;
            zero_o   <= w_fin_zero;
        end
    end

endmodule
`default_nettype wire
